yc_sync_prep: RTL and testbench
===============================

# yc_sync_prep

Front-end conditioning stage for the Analogizer Y/C encoder. It registers the core's RGB666 pixel stream and raw active-high syncs, measures line period and hsync width, and locks onto a stable line rate. It then emits blanked RGB666 plus hsync/vsync/csync, delay-matched, directly into the `din`/`hsync`/`vsync`/`csync` inputs of the downstream Y/C luma/chroma encoder. During vsync, csync carries 2H-rate serration pulses derived from the measured timing.

## Interface
Parameters:
- `CNT_W`, 12: width of line/pulse counters; counters saturate at 2^CNT_W-1.
- `LOCK_TOL`, 2: max |Δ| in clocks between consecutive line lengths still counted as "same".
- `MIN_LINE`, 256: minimum valid line length in clocks.

Ports:
- `clk` in 1: video clock, same clock as the Y/C encoder.
- `reset_n` in 1: reset; synchronous, active-low.
- `hs_in` in 1: raw hsync, active-high.
- `vs_in` in 1: raw vsync, active-high.
- `hblank` in 1: horizontal blanking, active-high.
- `vblank` in 1: vertical blanking, active-high.
- `rgb_in` in 18: RGB666, {R[17:12], G[11:6], B[5:0]}.
- `rgb_out` out 18: blanked RGB666 to encoder `din`.
- `hsync_o` out 1: hs_in delayed 2 clk.
- `vsync_o` out 1: vs_in delayed 2 clk.
- `csync_o` out 1: composite sync, active-high.
- `locked` out 1: line-rate lock status.
- `line_len` out CNT_W: last measured line length in clocks.

## Operation
- Stage 1 registers all inputs. `hs_prev` resets to 1, so an hs_in already high at reset release is not an edge.
- Line start is the rising edge of registered hs. At line start: `line_len <= h_cnt + 1`, then `h_cnt <= 0`. Otherwise `h_cnt` increments and saturates at max.
- `hs_w` is captured as the count from hs rise to hs fall, measured at the fall and saturating.
- `half = line_len >> 1`. `hs_w_eff = min(hs_w, half - 1)`.
- A line length is valid when MIN_LINE ≤ len < 2^CNT_W-1 and 1 ≤ hs_w ≤ len/4.
- Lock FSM, evaluated only at line start:
  - SEARCH: valid len → CANDIDATE, `ref <= len`. Otherwise stay.
  - CANDIDATE: valid and |len-ref| ≤ LOCK_TOL → LOCKED. Valid but out of tolerance → stay, `ref <= len`. Invalid → SEARCH.
  - LOCKED: invalid or |len-ref| > LOCK_TOL → SEARCH. Otherwise stay; `ref` is unchanged.
  - `h_cnt` saturating while LOCKED (hsync lost) → SEARCH immediately, without waiting for a line start.
- `locked = (state == LOCKED)`.
- csync:
  - Not locked, or vs low: `csync_o` = hs, delayed.
  - Locked and vs high: `csync_o = 0` for `hs_w_eff` clocks starting at h_cnt==0 and at h_cnt==half. Otherwise 1 (serrated, inverted sync).
- rgb_out = 0 when delayed (hblank|vblank); otherwise delayed rgb_in.

## Timing
- Fixed latency of 2 clk from every input to every output, including rgb/blank/sync alignment. No handshakes.
- Reset: all outputs 0; state SEARCH; h_cnt, line_len, hs_w, ref all 0.
- Reset mid-line: the next line length is valid only after two fresh hs rises.
- A vs edge in the same clock as a hs rise: the new vs value applies to that line's h_cnt==0 pulse.
- `locked` and `line_len` update the clock after the line-start edge is registered (stage 2).

## Structure
- Package `yc_pkg`: FSM enum `sync_state_t {SEARCH, CANDIDATE, LOCKED}`, and defaults for CNT_W, LOCK_TOL, MIN_LINE.
- Sub-module `sync_measure`: hs edge detect, h_cnt, line_len, hs_w capture. The top level holds the FSM, csync generation, and the delay pipes.

## Test plan
- Reset with hs_in held high → all outputs 0. No line start until a later hs rise; `locked` stays 0.
- Lines of 1716 clk with hs_w 128 → `line_len` = 1716 after the 2nd rise, `locked` = 1 after the 3rd rise. hsync_o/rgb_out match the inputs delayed exactly 2 clk.
- Locked, vs_in high for 3 lines → csync_o low 128 clk at h_cnt 0 and 858, high elsewhere. csync_o tracks hs when vs is low.
- Locked at 1716, then one line of 1720 → SEARCH, `locked` = 0. Two more 1716 lines → relocked. A 1717 line keeps the lock.
- Stop hs_in while locked → `locked` drops when h_cnt reaches 4095. csync_o follows hs (low).
- hblank pulse for 200 clk with rgb_in = 18'h3FFFF → rgb_out = 0 for exactly those 200 clk, delayed by 2.

Source files
------------

// File: rtl/yc_pkg.sv
// Shared types and defaults for the Y/C sync conditioning front end.
// The lock transition function lives here so the FSM and csync logic agree on it.
package yc_pkg;

    localparam int CNT_W_DEF    = 12;
    localparam int LOCK_TOL_DEF = 2;
    localparam int MIN_LINE_DEF = 256;

    typedef enum logic [1:0] {
        SEARCH,
        CANDIDATE,
        LOCKED
    } sync_state_t;

    // Lost hsync (saturated counter) only matters between line starts.
    function automatic sync_state_t lock_next(
        input sync_state_t cur,
        input logic        line_start,
        input logic        len_ok,
        input logic        in_tol,
        input logic        cnt_sat
    );
        sync_state_t nxt;
        nxt = cur;
        if (line_start) begin
            unique case (cur)
                SEARCH:    nxt = len_ok ? CANDIDATE : SEARCH;
                CANDIDATE: nxt = !len_ok ? SEARCH : (in_tol ? LOCKED : CANDIDATE);
                LOCKED:    nxt = (len_ok && in_tol) ? LOCKED : SEARCH;
                default:   nxt = SEARCH;
            endcase
        end else if (cnt_sat && (cur == LOCKED)) begin
            nxt = SEARCH;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/sync_measure.sv
// Line timing measurement on the stage-1 registered hsync: edge detect,
// free-running line counter, line length and hsync width capture.
module sync_measure
    import yc_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             hs_i,
    output logic             line_start_o,
    output logic [CNT_W-1:0] new_len_o,
    output logic [CNT_W-1:0] h_cnt_next_o,
    output logic [CNT_W-1:0] line_len_o,
    output logic [CNT_W-1:0] hs_w_o,
    output logic             cnt_sat_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             hs_prev_q;
    logic             fresh_q;
    logic             seen_q;
    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] line_len_q, line_len_d;
    logic [CNT_W-1:0] hs_w_q, hs_w_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             rise, fall;

    // A fall is only a width measurement if we saw the rise that started it.
    always_comb begin
        rise       = hs_i & ~hs_prev_q;
        fall       = ~hs_i & hs_prev_q;
        cnt_inc    = (h_cnt_q == CNT_MAX) ? CNT_MAX : h_cnt_q + 1'b1;
        h_cnt_d    = rise ? '0 : cnt_inc;
        line_len_d = rise ? cnt_inc : line_len_q;
        hs_w_d     = (fall && seen_q) ? cnt_inc : hs_w_q;
    end

    // fresh_q keeps the first post-reset cycle from seeing the stage-1 reset
    // value as a low, so an hsync already high at release is not an edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hs_prev_q  <= 1'b1;
            fresh_q    <= 1'b1;
            seen_q     <= 1'b0;
            h_cnt_q    <= '0;
            line_len_q <= '0;
            hs_w_q     <= '0;
        end else begin
            hs_prev_q  <= hs_i | fresh_q;
            fresh_q    <= 1'b0;
            seen_q     <= seen_q | rise;
            h_cnt_q    <= h_cnt_d;
            line_len_q <= line_len_d;
            hs_w_q     <= hs_w_d;
        end
    end

    assign line_start_o = rise;
    assign new_len_o    = cnt_inc;
    assign h_cnt_next_o = h_cnt_d;
    assign line_len_o   = line_len_q;
    assign hs_w_o       = hs_w_q;
    assign cnt_sat_o    = (h_cnt_q == CNT_MAX);

endmodule

// File: rtl/yc_sync_prep.sv
// Sync/pixel conditioning ahead of the Y/C encoder: 2-clk delay-matched RGB,
// syncs and csync, with line-rate lock and vsync serration.
module yc_sync_prep
    import yc_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int LOCK_TOL = LOCK_TOL_DEF,
    parameter int MIN_LINE = MIN_LINE_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             hs_in,
    input  logic             vs_in,
    input  logic             hblank,
    input  logic             vblank,
    input  logic [17:0]      rgb_in,
    output logic [17:0]      rgb_out,
    output logic             hsync_o,
    output logic             vsync_o,
    output logic             csync_o,
    output logic             locked,
    output logic [CNT_W-1:0] line_len
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] MIN_LEN = CNT_W'(MIN_LINE);
    localparam logic [CNT_W-1:0] TOL     = CNT_W'(LOCK_TOL);

    logic             hs_q, vs_q, blank_q;
    logic [17:0]      rgb_q;
    sync_state_t      state_q, state_d;
    logic [CNT_W-1:0] ref_len_q, ref_len_d;

    logic             line_start, cnt_sat;
    logic [CNT_W-1:0] new_len, h_cnt_next, hs_w;
    logic             len_ok, in_tol, in_pulse, csync_d;
    logic [CNT_W-1:0] len_diff, half, hs_w_eff;

    sync_measure #(.CNT_W(CNT_W)) u_measure (
        .clk          (clk),
        .reset_n      (reset_n),
        .hs_i         (hs_q),
        .line_start_o (line_start),
        .new_len_o    (new_len),
        .h_cnt_next_o (h_cnt_next),
        .line_len_o   (line_len),
        .hs_w_o       (hs_w),
        .cnt_sat_o    (cnt_sat)
    );

    // Serration is placed using the next counter value so the pulse at
    // h_cnt==0 lines up with the delayed hsync edge on the outputs.
    always_comb begin
        len_ok    = (new_len >= MIN_LEN) && (new_len < CNT_MAX) &&
                    (hs_w != '0) && (hs_w <= (new_len >> 2));
        len_diff  = (new_len >= ref_len_q) ? new_len - ref_len_q : ref_len_q - new_len;
        in_tol    = (len_diff <= TOL);
        state_d   = lock_next(state_q, line_start, len_ok, in_tol, cnt_sat);
        ref_len_d = ref_len_q;
        if (line_start && len_ok &&
            ((state_q == SEARCH) || ((state_q == CANDIDATE) && !in_tol))) begin
            ref_len_d = new_len;
        end
        half     = line_len >> 1;
        hs_w_eff = (half == '0) ? '0 : ((hs_w > half - 1'b1) ? half - 1'b1 : hs_w);
        in_pulse = (h_cnt_next < hs_w_eff) ||
                   ((h_cnt_next >= half) && ((h_cnt_next - half) < hs_w_eff));
        csync_d  = ((state_d == LOCKED) && vs_q) ? ~in_pulse : hs_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
            blank_q   <= 1'b0;
            rgb_q     <= '0;
            state_q   <= SEARCH;
            ref_len_q <= '0;
            rgb_out   <= '0;
            hsync_o   <= 1'b0;
            vsync_o   <= 1'b0;
            csync_o   <= 1'b0;
            locked    <= 1'b0;
        end else begin
            hs_q      <= hs_in;
            vs_q      <= vs_in;
            blank_q   <= hblank | vblank;
            rgb_q     <= rgb_in;
            state_q   <= state_d;
            ref_len_q <= ref_len_d;
            rgb_out   <= blank_q ? '0 : rgb_q;
            hsync_o   <= hs_q;
            vsync_o   <= vs_q;
            csync_o   <= csync_d;
            locked    <= (state_d == LOCKED);
        end
    end

endmodule

// File: tb/tb_yc_sync_prep.sv
// Directed bench for yc_sync_prep: reset, a delay/blanking vector table,
// then full 1716-clk lines for lock, serration, relock and lost hsync.
module tb_yc_sync_prep;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        hs_in = 1'b0, vs_in = 1'b0, hblank = 1'b0, vblank = 1'b0;
    logic [17:0] rgb_in = '0;
    logic [17:0] rgb_out;
    logic        hsync_o, vsync_o, csync_o, locked;
    logic [11:0] line_len;

    int checks = 0;
    int errors = 0;

    logic        prevHs = 1'b0, prevVs = 1'b0, prevBlank = 1'b0;
    logic [17:0] prevRgb = '0;

    typedef struct packed {
        logic        hs, vs, hb, vb;
        logic [17:0] rgb;
        logic        eHs, eVs, eCs;
        logic [17:0] eRgb;
    } vec_t;

    vec_t vecs [9];

    always #5 clk = ~clk;

    yc_sync_prep dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .hs_in    (hs_in),
        .vs_in    (vs_in),
        .hblank   (hblank),
        .vblank   (vblank),
        .rgb_in   (rgb_in),
        .rgb_out  (rgb_out),
        .hsync_o  (hsync_o),
        .vsync_o  (vsync_o),
        .csync_o  (csync_o),
        .locked   (locked),
        .line_len (line_len)
    );

    function automatic vec_t mkVec(input logic hs, input logic vs, input logic hb, input logic vb,
                                   input logic [17:0] rgb, input logic eHs, input logic eVs,
                                   input logic eCs, input logic [17:0] eRgb);
        vec_t v;
        v.hs = hs; v.vs = vs; v.hb = hb; v.vb = vb; v.rgb = rgb;
        v.eHs = eHs; v.eVs = eVs; v.eCs = eCs; v.eRgb = eRgb;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [17:0] actual, input logic [17:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Outputs are sampled 1 time unit after the edge that captured the inputs.
    task automatic applyStimulus(input logic hs, input logic vs, input logic hb, input logic vb,
                                 input logic [17:0] rgb);
        hs_in = hs; vs_in = vs; hblank = hb; vblank = vb; rgb_in = rgb;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic hs, input logic vs, input logic hb, input logic vb,
                        input logic [17:0] rgb);
        applyStimulus(hs, vs, hb, vb, rgb);
        checkOutput("hsync_delay", 18'(hsync_o), 18'(prevHs));
        checkOutput("vsync_delay", 18'(vsync_o), 18'(prevVs));
        checkOutput("rgb_delay", rgb_out, prevBlank ? 18'h0 : prevRgb);
        prevHs = hs; prevVs = vs; prevBlank = hb | vb; prevRgb = rgb;
    endtask

    // One line of L clocks, hsync high for the first W, hblank 200 clocks after it.
    task automatic runLine(input int L, input int W, input logic vsv, input bit chkSerr,
                           input bit chkLen, input int expLen, input logic expLock);
        int   blanks;
        int   half;
        int   p;
        logic hsv, hbv, expCs;
        blanks = 0;
        half   = L / 2;
        for (int c = 0; c < L; c++) begin
            hsv = (c < W);
            hbv = (c >= W) && (c < W + 200);
            step(hsv, vsv, hbv, vsv, 18'h3FFFF);
            if (c == 1) begin
                checkOutput("locked_at_line_start", 18'(locked), 18'(expLock));
                if (chkLen) checkOutput("line_len", 18'(line_len), 18'(expLen));
            end
            if (c >= 1) begin
                p = c - 1;
                if (rgb_out == 18'h0) blanks++;
                if (chkSerr) expCs = !((p < W) || ((p >= half) && (p < half + W)));
                else         expCs = (p < W);
                checkOutput(chkSerr ? "csync_serration" : "csync_tracks_hs", 18'(csync_o), 18'(expCs));
            end
        end
        if (!vsv) checkOutput("hblank_width", 18'(blanks), 18'd200);
    endtask

    initial begin
        int   c;
        int   dropC;
        logic dropped;

        vecs[0] = mkVec(1, 0, 0, 0, 18'h12345, 0, 0, 0, 18'h00000);
        vecs[1] = mkVec(1, 1, 0, 0, 18'h00001, 1, 0, 1, 18'h12345);
        vecs[2] = mkVec(0, 1, 1, 0, 18'h3FFFF, 1, 1, 1, 18'h00001);
        vecs[3] = mkVec(0, 0, 0, 1, 18'h2AAAA, 0, 1, 0, 18'h00000);
        vecs[4] = mkVec(1, 0, 1, 1, 18'h15555, 0, 0, 0, 18'h00000);
        vecs[5] = mkVec(0, 0, 0, 0, 18'h3F000, 1, 0, 1, 18'h00000);
        vecs[6] = mkVec(0, 1, 0, 0, 18'h00FC0, 0, 0, 0, 18'h3F000);
        vecs[7] = mkVec(1, 1, 0, 0, 18'h0003F, 0, 1, 0, 18'h00FC0);
        vecs[8] = mkVec(0, 0, 0, 0, 18'h00000, 1, 1, 1, 18'h0003F);

        reset_n = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, 0, 18'h3FFFF);
        checkOutput("reset_rgb_out", rgb_out, 18'h0);
        checkOutput("reset_hsync", 18'(hsync_o), 18'h0);
        checkOutput("reset_vsync", 18'(vsync_o), 18'h0);
        checkOutput("reset_csync", 18'(csync_o), 18'h0);
        checkOutput("reset_locked", 18'(locked), 18'h0);
        checkOutput("reset_line_len", 18'(line_len), 18'h0);

        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) applyStimulus(1, 0, 0, 0, 18'h3FFFF);
        checkOutput("held_high_hsync", 18'(hsync_o), 18'h1);
        checkOutput("held_high_no_line_start", 18'(line_len), 18'h0);
        for (int i = 0; i < 30; i++) applyStimulus(0, 0, 0, 0, 18'h0);
        checkOutput("fall_no_line_start", 18'(line_len), 18'h0);
        checkOutput("fall_not_locked", 18'(locked), 18'h0);

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].hs, vecs[i].vs, vecs[i].hb, vecs[i].vb, vecs[i].rgb);
            checkOutput("vec_hsync", 18'(hsync_o), 18'(vecs[i].eHs));
            checkOutput("vec_vsync", 18'(vsync_o), 18'(vecs[i].eVs));
            checkOutput("vec_csync", 18'(csync_o), 18'(vecs[i].eCs));
            checkOutput("vec_rgb", rgb_out, vecs[i].eRgb);
            checkOutput("vec_locked", 18'(locked), 18'h0);
        end
        prevHs = 1'b0; prevVs = 1'b0; prevBlank = 1'b0; prevRgb = '0;
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 18'h0);

        runLine(1716, 128, 0, 0, 0, 0,    0);
        runLine(1716, 128, 0, 0, 1, 1716, 0);
        runLine(1716, 128, 0, 0, 1, 1716, 1);
        runLine(1716, 128, 1, 1, 1, 1716, 1);
        runLine(1716, 128, 1, 1, 1, 1716, 1);
        runLine(1716, 128, 1, 1, 1, 1716, 1);
        runLine(1716, 128, 0, 0, 1, 1716, 1);
        runLine(1720, 128, 0, 0, 1, 1716, 1);
        runLine(1716, 128, 0, 0, 1, 1720, 0);
        runLine(1716, 128, 0, 0, 1, 1716, 0);
        runLine(1717, 128, 0, 0, 1, 1716, 1);
        runLine(1716, 128, 0, 0, 1, 1717, 1);

        // hsync stops: lock must drop once the line counter saturates.
        c       = 1716;
        dropped = 1'b0;
        dropC   = -1;
        while (!dropped && (c < 4400)) begin
            step(0, 0, 0, 0, 18'h3FFFF);
            if (c == 3800) checkOutput("locked_before_sat", 18'(locked), 18'h1);
            if (!locked) begin
                dropped = 1'b1;
                dropC   = c;
            end
            c++;
        end
        checkOutput("lock_dropped", 18'(dropped), 18'h1);
        if (dropped) checkOutput("lock_drop_cycle", 18'(dropC), 18'd4097);
        checkOutput("lost_hs_csync", 18'(csync_o), 18'h0);
        checkOutput("lost_hs_line_len", 18'(line_len), 18'd1717);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
